// File: rtl/fifo_mem_writeback.sv
// Result drain: five lane FIFOs collect systolic-array outputs and are written
// row-major to a memory port on init, with com raised when the matrix is written.

module fifo_wb_lane #(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_req,
    input  logic [DW-1:0] data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic          full,
    output logic          ovf
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count, count_nxt;
    logic          push;

    // A pop on the same edge frees the slot, so a full lane still accepts
    assign push  = push_req && (!full || pop);
    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (PW+1)'(DEPTH));
            if (push_req && full && !pop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data;
    end
endmodule

module fifo_mem_writeback #(
    parameter int DW    = 32,
    parameter int AW    = 8,
    parameter int DEPTH = 8,
    parameter int ROWS  = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic [AW-1:0] base_address,
    input  logic [4:0]    wr_en,
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [DW-1:0] in4,
    output logic [4:0]    full,
    output logic [4:0]    ovf,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          com
);
    localparam int LANES = 5;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t                     state;
    logic [LANES-1:0][DW-1:0]   lane_data, lane_head;
    logic [LANES-1:0]           lane_empty, pop;
    logic [2:0]                 lane;
    logic [RW-1:0]              row;
    logic [AW-1:0]              base_q, addr_calc;
    logic                       cur_ok, last;

    assign lane_data = {in4, in3, in2, in1, in0};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fifo_wb_lane #(.DW(DW), .DEPTH(DEPTH)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .push_req (wr_en[i]),
            .data     (lane_data[i]),
            .pop      (pop[i]),
            .head     (lane_head[i]),
            .empty    (lane_empty[i]),
            .full     (full[i]),
            .ovf      (ovf[i])
        );
    end

    // Strict in-order drain: an empty current lane stalls, never skipped
    assign cur_ok    = (state == DRAIN) && !lane_empty[lane];
    assign last      = (row == RW'(ROWS-1)) && (lane == 3'd4);
    assign addr_calc = base_q + AW'(row) * AW'(LANES) + AW'(lane);

    always_comb begin
        pop = '0;
        if (cur_ok) pop[lane] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            com       <= 1'b0;
            row       <= '0;
            lane      <= '0;
            base_q    <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (init) begin
                        base_q <= base_address;
                        row    <= '0;
                        lane   <= '0;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cur_ok) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_calc;
                        mem_wdata <= lane_head[lane];
                        if (lane == 3'd4) begin
                            lane <= '0;
                            row  <= row + 1'b1;
                        end else begin
                            lane <= lane + 3'd1;
                        end
                        if (last) begin
                            com   <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Requires init to drop before another drain can start
                    if (!init) begin
                        com   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_mem_writeback.sv
// Directed and randomized bench for fifo_mem_writeback against a queue-based
// model that tracks drain progress as a flat word index.

module tb_fifo_mem_writeback;
    logic        clk = 1'b0;
    logic        rst, init;
    logic [7:0]  base_address;
    logic [4:0]  wr_en;
    logic [31:0] din [5];
    logic [4:0]  full, ovf;
    logic        mem_we, com;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;

    always #5 clk = ~clk;

    fifo_mem_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .init         (init),
        .base_address (base_address),
        .wr_en        (wr_en),
        .in0          (din[0]),
        .in1          (din[1]),
        .in2          (din[2]),
        .in3          (din[3]),
        .in4          (din[4]),
        .full         (full),
        .ovf          (ovf),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .com          (com)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: queues per lane, phase 0 idle / 1 draining / 2 done, k = words written
    logic [31:0] mq [5][$];
    logic [4:0]  m_ovf;
    int          m_phase, m_k;
    logic [7:0]  m_base, m_addr;
    logic [31:0] m_wdata;
    logic        m_we, m_com;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        int popped;
        popped = -1;
        if (!rst) begin
            for (int i = 0; i < 5; i++) mq[i].delete();
            m_ovf = '0; m_phase = 0; m_k = 0;
            m_we = 0; m_com = 0; m_addr = '0; m_wdata = '0;
            return;
        end
        m_we = 0;
        case (m_phase)
            0: if (init) begin m_base = base_address; m_k = 0; m_phase = 1; end
            1: begin
                if (mq[m_k % 5].size() > 0) begin
                    popped  = m_k % 5;
                    m_we    = 1;
                    m_addr  = m_base + 8'(m_k);
                    m_wdata = mq[popped][0];
                    if (m_k == 24) begin m_com = 1; m_phase = 2; end
                    m_k++;
                end
            end
            default: if (!init) begin m_com = 0; m_phase = 0; end
        endcase
        if (popped >= 0) void'(mq[popped].pop_front());
        for (int i = 0; i < 5; i++) begin
            if (wr_en[i]) begin
                if (mq[i].size() < 8) mq[i].push_back(din[i]);
                else m_ovf[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [4:0] fe;
        for (int i = 0; i < 5; i++) fe[i] = (mq[i].size() == 8);
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("com", 32'(com), 32'(m_com));
        chk("full", 32'(full), 32'(fe));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        if (m_we) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic rand_data();
        for (int i = 0; i < 5; i++) din[i] = $urandom;
    endtask

    initial begin
        m_ovf = '0; m_phase = 0; m_k = 0; m_base = '0;
        m_we = 0; m_com = 0; m_addr = '0; m_wdata = '0;
        rst = 1'b0; init = 1'b0; base_address = '0; wr_en = 5'b11111;
        rand_data();

        // Reset with pushes requested: nothing must be retained
        step(); step();
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        rst = 1'b1; wr_en = '0;
        step(); step();

        // Full drain, lane i word r = i*16+r
        for (int r = 0; r < 5; r++) begin
            wr_en = 5'b11111;
            for (int i = 0; i < 5; i++) din[i] = 32'(i * 16 + r);
            step();
        end
        wr_en = '0; base_address = 8'h10; init = 1'b1;
        repeat (27) step();
        chk("drain_com_held", 32'(com), 32'h1);
        init = 1'b0;
        step();
        chk("drain_com_clear", 32'(com), 32'h0);
        step();

        // Stall on empty lane 2, then release it
        wr_en = 5'b00011; rand_data(); step();
        wr_en = '0; base_address = 8'h40; init = 1'b1;
        repeat (6) step();
        chk("stall_we", 32'(mem_we), 32'h0);
        wr_en = 5'b00100; din[2] = $urandom; step();
        wr_en = '0; step(); step();
        rst = 1'b0; init = 1'b0; step();
        rst = 1'b1; step();

        // Overflow lane 3, then drain through it
        wr_en = 5'b01000;
        repeat (9) begin din[3] = $urandom; step(); end
        chk("ovf_full3", 32'(full[3]), 32'h1);
        chk("ovf_flag3", 32'(ovf[3]), 32'h1);
        wr_en = 5'b10111;
        repeat (5) begin rand_data(); step(); end
        wr_en = '0; base_address = 8'($urandom); init = 1'b1;
        repeat (28) step();
        init = 1'b0; step(); step();
        rst = 1'b0; step();
        rst = 1'b1; step();

        // Push into full lane 3 exactly on its pop edges
        wr_en = 5'b11111;
        repeat (8) begin rand_data(); step(); end
        wr_en = '0; base_address = 8'($urandom); init = 1'b1;
        repeat (30) begin
            wr_en = (m_phase == 1 && m_k % 5 == 3 && mq[3].size() > 0) ? 5'b01000 : 5'b00000;
            din[3] = $urandom;
            step();
        end
        wr_en = '0;
        chk("pp_ovf3", 32'(ovf[3]), 32'h0);
        chk("pp_full3", 32'(full[3]), 32'h1);
        init = 1'b0; step();
        rst = 1'b0; step();
        rst = 1'b1; step();

        // Address wrap from 0xF0
        wr_en = 5'b11111;
        repeat (5) begin rand_data(); step(); end
        wr_en = '0; base_address = 8'hF0; init = 1'b1;
        repeat (27) step();
        init = 1'b0; step();

        // Reset mid-drain discards everything
        wr_en = 5'b11111;
        repeat (5) begin rand_data(); step(); end
        wr_en = '0; base_address = 8'($urandom); init = 1'b1;
        repeat (7) step();
        rst = 1'b0; init = 1'b0; step();
        chk("midrst_we", 32'(mem_we), 32'h0);
        chk("midrst_com", 32'(com), 32'h0);
        rst = 1'b1; step();
        init = 1'b1; repeat (4) step();
        chk("midrst_empty", 32'(mem_we), 32'h0);
        init = 1'b0; step(); step();

        // Randomized traffic
        repeat (500) begin
            rst = ($urandom % 150) != 0;
            if ($urandom % 8 == 0) init = ~init;
            wr_en = 5'($urandom);
            rand_data();
            base_address = 8'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
